oam_dma_arbiter: RTL and testbench

Bus arbiter and sprite-DMA sequencer between the M6502 core and the system bus. It normally passes CPU cycles straight through. A CPU write to the DMA trigger register stalls the CPU via RDY and copies one 256-byte page to the PPU OAM data port, alternating read and write cycles. Bus ownership then returns to the CPU. It sits between the `M6502` address/data/rw pins and the memory/PPU decode.

---
 rtl/oam_dma_arbiter_if.sv | 26 ++
 rtl/oam_dma_arbiter.sv | 105 ++++++++++
 tb/tb_oam_dma_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and system-bus-side signals of the sprite-DMA bus arbiter.
// The slave modport is the arbiter; the master modport is the CPU/bus environment.
interface oam_dma_arbiter_if;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_rw;
    logic [7:0]  i_cpu_wdata;
    logic [7:0]  o_cpu_rdata;
    logic        o_cpu_rdy;
    logic [15:0] o_bus_addr;
    logic        o_bus_rw;
    logic [7:0]  o_bus_wdata;
    logic [7:0]  i_bus_rdata;
    logic        o_dma_active;

    modport slave (
        input  i_cpu_addr, i_cpu_rw, i_cpu_wdata, i_bus_rdata,
        output o_cpu_rdata, o_cpu_rdy, o_bus_addr, o_bus_rw,
        output o_bus_wdata, o_dma_active
    );

    modport master (
        output i_cpu_addr, i_cpu_rw, i_cpu_wdata, i_bus_rdata,
        input  o_cpu_rdata, o_cpu_rdy, o_bus_addr, o_bus_rw,
        input  o_bus_wdata, o_dma_active
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Passes 6502 cycles to the system bus and, on a trigger write, stalls the
// CPU while copying one 256-byte page to the PPU OAM data port.
module oam_dma_arbiter #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input logic            i_clk,
    input logic            i_rst,
    oam_dma_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;
    logic       rdy_q, rdy_d;
    logic       active_q, active_d;
    logic       trig;

    assign trig = !bus.i_cpu_rw && (bus.i_cpu_addr == TRIGGER_ADDR);

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        latch_d  = latch_q;
        parity_d = ~parity_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    page_d  = bus.i_cpu_wdata;
                    index_d = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // A 6502 ignores RDY on writes, so only a read can halt it.
                if (!bus.i_cpu_rw) begin
                    if (trig) page_d = bus.i_cpu_wdata;
                end else begin
                    state_d = parity_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                latch_d = bus.i_bus_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                index_d = index_q + 8'h01;
                state_d = (index_q == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d    = (state_d == S_IDLE);
        active_d = (state_d == S_ALIGN) || (state_d == S_READ) ||
                   (state_d == S_WRITE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
            rdy_q    <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            latch_q  <= latch_d;
            parity_q <= parity_d;
            rdy_q    <= rdy_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        bus.o_bus_addr  = bus.i_cpu_addr;
        bus.o_bus_rw    = bus.i_cpu_rw;
        bus.o_bus_wdata = bus.i_cpu_wdata;
        unique case (state_q)
            S_READ: begin
                bus.o_bus_addr = {page_q, index_q};
                bus.o_bus_rw   = 1'b1;
            end
            S_WRITE: begin
                bus.o_bus_addr  = OAM_DATA_ADDR;
                bus.o_bus_rw    = 1'b0;
                bus.o_bus_wdata = latch_q;
            end
            default: ;
        endcase
    end

    assign bus.o_cpu_rdata  = bus.i_bus_rdata;
    assign bus.o_cpu_rdy    = rdy_q;
    assign bus.o_dma_active = active_q;
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: memory and OAM models, per-cycle
// schedule checks of the DMA sequence.
module tb_oam_dma_arbiter;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    oam_dma_arbiter_if bus_if ();

    oam_dma_arbiter dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_if)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] mem [0:65535];
    assign bus_if.i_bus_rdata = mem[bus_if.o_bus_addr];

    int n_checks = 0;
    int n_fail   = 0;
    logic par_m;
    logic [7:0] oam [0:255];
    int oam_n;
    logic oam_clr = 1'b0;

    always @(posedge i_clk) par_m <= i_rst ? 1'b0 : ~par_m;

    always @(posedge i_clk) begin
        if (oam_clr) oam_n = 0;
        else if (!i_rst && bus_if.o_dma_active && !bus_if.o_bus_rw &&
                 bus_if.o_bus_addr == 16'h2004) begin
            if (oam_n < 256) oam[oam_n] = bus_if.o_bus_wdata;
            oam_n = oam_n + 1;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] pg,
                                            input logic [7:0] i);
        case (pg)
            8'h03:   return i ^ 8'hA5;
            8'h07:   return i + 8'h30;
            8'hFF:   return ~i;
            default: return i;
        endcase
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic rw,
                         input logic [7:0] d);
        bus_if.i_cpu_addr  = a;
        bus_if.i_cpu_rw    = rw;
        bus_if.i_cpu_wdata = d;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(16'h1234, 1'b1, 8'h00);
        step();
        step();
        n_checks++;
        if (bus_if.o_cpu_rdy !== 1'b1 || bus_if.o_dma_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy=%b act=%b want 1 0",
                     bus_if.o_cpu_rdy, bus_if.o_dma_active);
        end
        i_rst = 1'b0;
        step();
        drive(16'h1234, 1'b1, 8'h00);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw} !== {16'h1234, 1'b1} ||
            bus_if.o_cpu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: addr=%h rw=%b rdy=%b want 1234 1 1",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_cpu_rdy);
        end
        step();
    endtask

    task automatic test_pass_through();
        drive(16'h8000, 1'b1, 8'h00);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_cpu_rdata}
            !== {16'h8000, 1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL pt_read: addr=%h rw=%b rdata=%h want 8000 1 3c",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_cpu_rdata);
        end
        step();
        drive(16'h0200, 1'b0, 8'h5A);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata}
            !== {16'h0200, 1'b0, 8'h5A}) begin
            n_fail++;
            $display("FAIL pt_write: addr=%h rw=%b wd=%h want 0200 0 5a",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata);
        end
        n_checks++;
        if (bus_if.o_cpu_rdy !== 1'b1 || bus_if.o_dma_active !== 1'b0) begin
            n_fail++;
            $display("FAIL pt_flags: rdy=%b act=%b want 1 0",
                     bus_if.o_cpu_rdy, bus_if.o_dma_active);
        end
        step();
    endtask

    // Trigger when model parity equals trig_par: 0 gives an aligned halt.
    task automatic do_trigger(input logic [7:0] pg, input logic trig_par);
        oam_clr = 1'b1;
        drive(16'h8000, 1'b1, 8'h00);
        step();
        oam_clr = 1'b0;
        for (int g = 0; g < 4 && par_m !== trig_par; g++) begin
            drive(16'h8000, 1'b1, 8'h00);
            step();
        end
        drive(16'h4014, 1'b0, pg);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
             bus_if.o_cpu_rdy} !== {16'h4014, 1'b0, pg, 1'b1}) begin
            n_fail++;
            $display("FAIL trig_pass: addr=%h rw=%b wd=%h rdy=%b want 4014 0 %h 1",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
                     bus_if.o_cpu_rdy, pg);
        end
        step();
    endtask

    // CPU holds a read from here; checks every cycle of the expected schedule.
    task automatic drain(input logic [7:0] pg, input int npairs,
                         input logic exp_align, input string nm);
        logic align;
        align = (par_m === 1'b0);
        n_checks++;
        if (align !== exp_align) begin
            n_fail++;
            $display("FAIL %s_setup: align=%b want %b", nm, align, exp_align);
        end
        drive(16'h8123, 1'b1, 8'h00);
        n_checks++;
        if ({bus_if.o_cpu_rdy, bus_if.o_dma_active, bus_if.o_bus_addr,
             bus_if.o_bus_rw} !== {1'b0, 1'b0, 16'h8123, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_halt: rdy=%b act=%b addr=%h rw=%b want 0 0 8123 1",
                     nm, bus_if.o_cpu_rdy, bus_if.o_dma_active,
                     bus_if.o_bus_addr, bus_if.o_bus_rw);
        end
        step();
        if (align) begin
            n_checks++;
            if ({bus_if.o_cpu_rdy, bus_if.o_dma_active, bus_if.o_bus_addr,
                 bus_if.o_bus_rw} !== {1'b0, 1'b1, 16'h8123, 1'b1}) begin
                n_fail++;
                $display("FAIL %s_align: rdy=%b act=%b addr=%h want 0 1 8123",
                         nm, bus_if.o_cpu_rdy, bus_if.o_dma_active,
                         bus_if.o_bus_addr);
            end
            step();
        end
        for (int p = 0; p < npairs; p++) begin
            n_checks++;
            if ({bus_if.o_cpu_rdy, bus_if.o_dma_active, bus_if.o_bus_addr,
                 bus_if.o_bus_rw} !== {1'b0, 1'b1, pg, p[7:0], 1'b1}) begin
                n_fail++;
                $display("FAIL %s_read%0d: rdy=%b act=%b addr=%h rw=%b want 0 1 %h%h 1",
                         nm, p, bus_if.o_cpu_rdy, bus_if.o_dma_active,
                         bus_if.o_bus_addr, bus_if.o_bus_rw, pg, p[7:0]);
            end
            step();
            n_checks++;
            if ({bus_if.o_cpu_rdy, bus_if.o_bus_addr, bus_if.o_bus_rw,
                 bus_if.o_bus_wdata} !==
                {1'b0, 16'h2004, 1'b0, exp_byte(pg, p[7:0])}) begin
                n_fail++;
                $display("FAIL %s_write%0d: rdy=%b addr=%h rw=%b wd=%h want 0 2004 0 %h",
                         nm, p, bus_if.o_cpu_rdy, bus_if.o_bus_addr,
                         bus_if.o_bus_rw, bus_if.o_bus_wdata,
                         exp_byte(pg, p[7:0]));
            end
            step();
        end
        if (npairs == 256) begin
            n_checks++;
            if ({bus_if.o_cpu_rdy, bus_if.o_dma_active, bus_if.o_bus_addr,
                 bus_if.o_bus_rw} !== {1'b1, 1'b0, 16'h8123, 1'b1}) begin
                n_fail++;
                $display("FAIL %s_done: rdy=%b act=%b addr=%h want 1 0 8123",
                         nm, bus_if.o_cpu_rdy, bus_if.o_dma_active,
                         bus_if.o_bus_addr);
            end
            n_checks++;
            if (oam_n !== 256) begin
                n_fail++;
                $display("FAIL %s_oam_count: got %0d want 256", nm, oam_n);
            end
            for (int i = 0; i < 256; i++) begin
                n_checks++;
                if (oam[i] !== exp_byte(pg, i[7:0])) begin
                    n_fail++;
                    $display("FAIL %s_oam%0d: got %h want %h",
                             nm, i, oam[i], exp_byte(pg, i[7:0]));
                end
            end
            step();
        end
    endtask

    task automatic test_aligned();
        do_trigger(8'h03, 1'b0);
        drain(8'h03, 256, 1'b0, "aligned");
    endtask

    task automatic test_misaligned();
        do_trigger(8'h03, 1'b1);
        drain(8'h03, 256, 1'b1, "misaligned");
    endtask

    task automatic test_halt_writes();
        logic par0;
        do_trigger(8'h03, 1'b0);
        par0 = par_m;
        drive(16'h0200, 1'b0, 8'h11);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
             bus_if.o_cpu_rdy, bus_if.o_dma_active} !==
            {16'h0200, 1'b0, 8'h11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hw_write1: addr=%h rw=%b wd=%h rdy=%b act=%b want 0200 0 11 0 0",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
                     bus_if.o_cpu_rdy, bus_if.o_dma_active);
        end
        step();
        drive(16'h4014, 1'b0, 8'h07);
        n_checks++;
        if ({bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
             bus_if.o_cpu_rdy, bus_if.o_dma_active} !==
            {16'h4014, 1'b0, 8'h07, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hw_write2: addr=%h rw=%b wd=%h rdy=%b act=%b want 4014 0 07 0 0",
                     bus_if.o_bus_addr, bus_if.o_bus_rw, bus_if.o_bus_wdata,
                     bus_if.o_cpu_rdy, bus_if.o_dma_active);
        end
        step();
        drain(8'h07, 256, ~par0, "halt_writes");
    endtask

    task automatic test_page_wrap();
        do_trigger(8'hFF, 1'b0);
        drain(8'hFF, 256, 1'b0, "wrap");
        drive(16'h8000, 1'b1, 8'h00);
        n_checks++;
        if ({bus_if.o_cpu_rdy, bus_if.o_bus_addr} !== {1'b1, 16'h8000}) begin
            n_fail++;
            $display("FAIL wrap_idle: rdy=%b addr=%h want 1 8000",
                     bus_if.o_cpu_rdy, bus_if.o_bus_addr);
        end
        step();
    endtask

    task automatic test_reset_mid_dma();
        do_trigger(8'h03, 1'b0);
        drain(8'h03, 100, 1'b0, "rst_mid");
        i_rst = 1'b1;
        drive(16'h8000, 1'b1, 8'h00);
        step();
        i_rst = 1'b0;
        drive(16'h8000, 1'b1, 8'h00);
        n_checks++;
        if ({bus_if.o_cpu_rdy, bus_if.o_dma_active, bus_if.o_bus_addr,
             bus_if.o_bus_rw} !== {1'b1, 1'b0, 16'h8000, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_idle: rdy=%b act=%b addr=%h rw=%b want 1 0 8000 1",
                     bus_if.o_cpu_rdy, bus_if.o_dma_active,
                     bus_if.o_bus_addr, bus_if.o_bus_rw);
        end
        n_checks++;
        if (oam_n !== 100) begin
            n_fail++;
            $display("FAIL rst_mid_oam_count: got %0d want 100", oam_n);
        end
        step();
        step();
        n_checks++;
        if (oam_n !== 100 || bus_if.o_cpu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_stays: oam=%0d rdy=%b want 100 1",
                     oam_n, bus_if.o_cpu_rdy);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 256; i++) begin
            mem[{8'h03, i[7:0]}] = i[7:0] ^ 8'hA5;
            mem[{8'h07, i[7:0]}] = i[7:0] + 8'h30;
            mem[{8'hFF, i[7:0]}] = ~i[7:0];
        end
        mem[16'h8000] = 8'h3C;
        bus_if.i_cpu_addr  = 16'h0000;
        bus_if.i_cpu_rw    = 1'b1;
        bus_if.i_cpu_wdata = 8'h00;
        test_reset();
        test_pass_through();
        test_aligned();
        test_misaligned();
        test_halt_writes();
        test_page_wrap();
        test_reset_mid_dma();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
